acl2_init_sequencer: RTL and testbench

ACL2_INIT_SEQUENCER -- requirements
Module: acl2_init_sequencer

---
 rtl/acl2_init_sequencer.sv | 137 +++++++++++++
 tb/tb_acl2_init_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acl2_init_sequencer.sv
// Power-up register-write sequencer for the ADXL362 (ACL2) accelerometer.
// Issues a fixed three-entry write table to an SPI master with timeout supervision.
module acl2_init_sequencer #(
    parameter logic [15:0] STARTUP_CYCLES = 16'd5000,
    parameter logic [15:0] GAP_CYCLES     = 16'd500,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
    input  logic       clk_sys,
    input  logic       reset_sys,
    input  logic       restart,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    input  logic       cmd_done,
    output logic       init_busy,
    output logic       init_done,
    output logic       init_error,
    output logic [1:0] step
);

    // A zero-length wait would make the terminal-count compare underflow, so 0 means 1.
    localparam logic [15:0] STARTUP_EFF = (STARTUP_CYCLES == 16'd0) ? 16'd1 : STARTUP_CYCLES;
    localparam logic [15:0] GAP_EFF     = (GAP_CYCLES == 16'd0)     ? 16'd1 : GAP_CYCLES;
    localparam logic [15:0] TIMEOUT_EFF = (TIMEOUT_CYCLES == 16'd0) ? 16'd1 : TIMEOUT_CYCLES;
    localparam logic [1:0]  LAST_STEP   = 2'd2;

    typedef enum logic [2:0] {
        WAIT_PWR,
        ISSUE,
        WAIT_DONE,
        GAP,
        DONE,
        ERROR
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_PWR: begin
                if (cnt_q == STARTUP_EFF - 16'd1) begin
                    state_d = ISSUE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_d = WAIT_DONE;
                    cnt_d   = 16'd0;
                end
            end
            WAIT_DONE: begin
                // cmd_done is tested first so it wins a tie with timeout expiry.
                if (cmd_done) begin
                    state_d = GAP;
                    cnt_d   = 16'd0;
                end else if (cnt_q == TIMEOUT_EFF - 16'd1) begin
                    state_d = ERROR;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            GAP: begin
                if (cnt_q == GAP_EFF - 16'd1) begin
                    cnt_d = 16'd0;
                    if (step_q < LAST_STEP) begin
                        step_d  = step_q + 2'd1;
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DONE, ERROR: begin
                if (restart) begin
                    state_d = WAIT_PWR;
                    step_d  = 2'd0;
                    cnt_d   = 16'd0;
                end
            end
            default: begin
                state_d = WAIT_PWR;
                step_d  = 2'd0;
                cnt_d   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset_sys) begin
            state_q <= WAIT_PWR;
            step_q  <= 2'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are pure decodes of registered state, so they are glitch-free per cycle.
    always_comb begin
        cmd_valid = (state_q == ISSUE);
        cmd_addr  = 8'h00;
        cmd_data  = 8'h00;
        if (state_q == ISSUE) begin
            case (step_q)
                2'd0:    begin cmd_addr = 8'h1F; cmd_data = 8'h52; end
                2'd1:    begin cmd_addr = 8'h2C; cmd_data = 8'h13; end
                2'd2:    begin cmd_addr = 8'h2D; cmd_data = 8'h02; end
                default: begin cmd_addr = 8'h00; cmd_data = 8'h00; end
            endcase
        end
        init_busy  = (state_q == WAIT_PWR) || (state_q == ISSUE) ||
                     (state_q == WAIT_DONE) || (state_q == GAP);
        init_done  = (state_q == DONE);
        init_error = (state_q == ERROR);
        step       = step_q;
    end

endmodule

// File: tb/tb_acl2_init_sequencer.sv
// Directed self-checking bench for acl2_init_sequencer with short timing parameters.
module tb_acl2_init_sequencer;

    logic       clk_sys = 1'b0;
    logic       reset_sys;
    logic       restart;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_done;
    logic       init_busy;
    logic       init_done;
    logic       init_error;
    logic [1:0] step;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    acl2_init_sequencer #(
        .STARTUP_CYCLES(16'd10),
        .GAP_CYCLES    (16'd4),
        .TIMEOUT_CYCLES(16'd20)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_sys (reset_sys),
        .restart   (restart),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_done  (cmd_done),
        .init_busy (init_busy),
        .init_done (init_done),
        .init_error(init_error),
        .step      (step)
    );

    always #5 clk_sys = ~clk_sys;

    // Advance one rising edge; inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
        cyc++;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic watched(input int which);
        case (which)
            0:       return cmd_valid;
            1:       return init_done;
            default: return init_error;
        endcase
    endfunction

    task automatic wait_for(input int which, input int max_cycles, input string tag);
        int n = 0;
        while (watched(which) !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, int'(watched(which)), 1);
    endtask

    function automatic int exp_addr(input int s);
        case (s)
            0:       return 'h1F;
            1:       return 'h2C;
            default: return 'h2D;
        endcase
    endfunction

    function automatic int exp_data(input int s);
        case (s)
            0:       return 'h52;
            1:       return 'h13;
            default: return 'h02;
        endcase
    endfunction

    // Wait for the command, check it, accept it (cmd_ready must be 1) and pulse cmd_done next cycle.
    task automatic run_cmd(input int s);
        wait_for(0, 100, "cmd_valid_seen");
        check("cmd_step", int'(step), s);
        check("cmd_addr", int'(cmd_addr), exp_addr(s));
        check("cmd_data", int'(cmd_data), exp_data(s));
        tick();
        check("valid_drop_after_accept", int'(cmd_valid), 0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
    endtask

    initial begin
        reset_sys = 1'b1;
        restart   = 1'b0;
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        @(negedge clk_sys);
        tick();
        tick();
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_addr", int'(cmd_addr), 0);
        check("rst_data", int'(cmd_data), 0);
        check("rst_busy", int'(init_busy), 1);
        check("rst_done", int'(init_done), 0);
        check("rst_error", int'(init_error), 0);
        check("rst_step", int'(step), 0);

        // Nominal run: ISSUE at cycles 10, 16, 22; init_done at cycle 28.
        reset_sys = 1'b0;
        cmd_ready = 1'b1;
        cyc = 0;
        wait_for(0, 100, "nom_first_valid");
        check("nom_issue0_cycle", cyc, 10);
        run_cmd(0);
        wait_for(0, 100, "nom_second_valid");
        check("nom_issue1_cycle", cyc, 16);
        run_cmd(1);
        run_cmd(2);
        wait_for(1, 100, "nom_init_done");
        check("nom_done_cycle", cyc, 28);
        check("nom_done_busy", int'(init_busy), 0);
        check("nom_done_step", int'(step), 2);
        check("nom_done_error", int'(init_error), 0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        tick();
        check("done_terminal", int'(init_done), 1);
        check("done_no_valid", int'(cmd_valid), 0);

        // Restart from DONE, then backpressure on step 1 and an ignored restart in GAP.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        cyc = 0;
        check("rs_busy", int'(init_busy), 1);
        check("rs_step", int'(step), 0);
        check("rs_done_clear", int'(init_done), 0);
        run_cmd(0);
        check("rs_issue0_cycle", cyc, 12);
        cmd_ready = 1'b0;
        wait_for(0, 100, "bp_valid");
        for (int i = 0; i < 7; i++) begin
            check("bp_hold_valid", int'(cmd_valid), 1);
            check("bp_hold_addr", int'(cmd_addr), 'h2C);
            check("bp_hold_data", int'(cmd_data), 'h13);
            tick();
        end
        cmd_ready = 1'b1;
        check("bp_ready_valid", int'(cmd_valid), 1);
        tick();
        check("bp_single_accept", int'(cmd_valid), 0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("gap_restart_ignored_step", int'(step), 1);
        check("gap_restart_ignored_busy", int'(init_busy), 1);
        run_cmd(2);
        wait_for(1, 100, "bp_init_done");

        // Timeout: step 0 accepted, no cmd_done -> ERROR 20 cycles after the accept edge.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        wait_for(0, 100, "to_valid");
        tick();
        acc_cyc = cyc;
        wait_for(2, 100, "to_init_error");
        check("to_error_latency", cyc - acc_cyc, 20);
        check("to_valid_low", int'(cmd_valid), 0);
        check("to_step", int'(step), 0);
        check("to_busy", int'(init_busy), 0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        tick();
        check("err_sticky", int'(init_error), 1);

        // Restart from ERROR; cmd_done on the 20th WAIT_DONE cycle wins over the timeout.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        cyc = 0;
        check("err_restart_step", int'(step), 0);
        check("err_restart_error", int'(init_error), 0);
        wait_for(0, 100, "tie_valid");
        check("tie_issue0_cycle", cyc, 10);
        check("tie_addr", int'(cmd_addr), 'h1F);
        tick();
        for (int i = 0; i < 19; i++) tick();
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        check("tie_no_error", int'(init_error), 0);
        check("tie_busy", int'(init_busy), 1);
        run_cmd(1);
        check("tie_step1_done_busy", int'(init_busy), 1);

        // Reset while step 2 is held in ISSUE: cmd_valid drops, sequence restarts at step 0.
        cmd_ready = 1'b0;
        wait_for(0, 100, "mid_valid");
        check("mid_step", int'(step), 2);
        tick();
        check("mid_hold", int'(cmd_valid), 1);
        reset_sys = 1'b1;
        cmd_ready = 1'b1;
        tick();
        check("mid_rst_valid", int'(cmd_valid), 0);
        check("mid_rst_step", int'(step), 0);
        check("mid_rst_busy", int'(init_busy), 1);
        reset_sys = 1'b0;
        cyc = 0;
        wait_for(0, 100, "post_rst_valid");
        check("post_rst_issue_cycle", cyc, 10);
        run_cmd(0);
        run_cmd(1);
        run_cmd(2);
        wait_for(1, 100, "post_rst_done");
        check("post_rst_done_cycle", cyc, 28);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the directed sequence stalls somewhere unexpected.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
